mem_buffer_arbiter: RTL and testbench

//  Two-requester controller that shares one memory_buffer instance (single port, explicit address).

---
 rtl/mem_buffer_pkg.sv | 6 +
 rtl/rr_arbiter2.sv | 25 ++
 rtl/mem_buffer_arbiter.sv | 159 +++++++++++++++
 tb/tb_mem_buffer_arbiter.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/mem_buffer_pkg.sv
// Shared encodings for the two-requester memory_buffer controller.
package mem_buffer_pkg;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_CMD = 2'd1, ST_RWAIT = 2'd2} state_t;
  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;
endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin: on a tie the requester not granted last wins.
module rr_arbiter2
  import mem_buffer_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  input  logic req_a,
  input  logic req_b,
  input  logic take,
  output logic any,
  output logic gnt_id
);
  logic last;

  always_comb begin
    any = req_a | req_b;
    if (req_a && req_b) gnt_id = (last == REQ_A) ? REQ_B : REQ_A;
    else                gnt_id = req_b ? REQ_B : REQ_A;
  end

  // Reset as if B went last so A wins the first tie.
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n)         last <= REQ_B;
    else if (take && any) last <= gnt_id;
endmodule

// File: rtl/mem_buffer_arbiter.sv
// Arbitrates A/B onto a single-port memory_buffer, one command at a time,
// and tracks per-entry occupancy for full/empty/count.
module mem_buffer_arbiter
  import mem_buffer_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int DEPTH       = 8,
  parameter int ADDR_W      = 3,
  parameter bit READ_CLEARS = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [WIDTH-1:0]  a_wdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [WIDTH-1:0]  b_wdata,
  output logic              a_gnt,
  output logic              a_ack,
  output logic [WIDTH-1:0]  a_rdata,
  output logic              a_rerr,
  output logic              b_gnt,
  output logic              b_ack,
  output logic [WIDTH-1:0]  b_rdata,
  output logic              b_rerr,
  output logic              mem_en_w,
  output logic              mem_en_r,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WIDTH-1:0]  mem_wdata,
  input  logic [WIDTH-1:0]  mem_rdata,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count
);
  state_t             state, state_d;
  logic               owner, owner_d, op_we, op_we_d;
  logic [DEPTH-1:0]   valid, valid_d;
  logic               arb_any, arb_id, arb_take;
  logic               a_gnt_d, b_gnt_d, a_ack_d, b_ack_d, a_rerr_d, b_rerr_d;
  logic               mem_en_w_d, mem_en_r_d;
  logic [ADDR_W-1:0]  mem_addr_d;
  logic [WIDTH-1:0]   mem_wdata_d, a_rdata_d, b_rdata_d;
  logic [ADDR_W:0]    count_d;

  rr_arbiter2 u_arb (
    .clk(clk), .reset_n(reset_n), .req_a(a_req), .req_b(b_req),
    .take(arb_take), .any(arb_any), .gnt_id(arb_id)
  );

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_d;

  // mem_addr/mem_wdata double as the latched command; they hold until the next grant.
  always_comb begin
    state_d     = state;
    owner_d     = owner;
    op_we_d     = op_we;
    valid_d     = valid;
    arb_take    = 1'b0;
    a_gnt_d     = 1'b0;
    b_gnt_d     = 1'b0;
    a_ack_d     = 1'b0;
    b_ack_d     = 1'b0;
    a_rerr_d    = 1'b0;
    b_rerr_d    = 1'b0;
    a_rdata_d   = a_rdata;
    b_rdata_d   = b_rdata;
    mem_en_w_d  = 1'b0;
    mem_en_r_d  = 1'b0;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    case (state)
      ST_IDLE: if (arb_any) begin
        arb_take    = 1'b1;
        owner_d     = arb_id;
        op_we_d     = (arb_id == REQ_B) ? b_we    : a_we;
        mem_addr_d  = (arb_id == REQ_B) ? b_addr  : a_addr;
        mem_wdata_d = (arb_id == REQ_B) ? b_wdata : a_wdata;
        a_gnt_d     = (arb_id == REQ_A);
        b_gnt_d     = (arb_id == REQ_B);
        mem_en_w_d  = op_we_d;
        mem_en_r_d  = !op_we_d;
        state_d     = ST_CMD;
      end
      ST_CMD: begin
        if (op_we) begin
          valid_d[mem_addr] = 1'b1;
          a_ack_d = (owner == REQ_A);
          b_ack_d = (owner == REQ_B);
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RWAIT;
        end
      end
      ST_RWAIT: begin
        if (owner == REQ_A) begin
          a_rdata_d = mem_rdata;
          a_rerr_d  = !valid[mem_addr];
          a_ack_d   = 1'b1;
        end else begin
          b_rdata_d = mem_rdata;
          b_rerr_d  = !valid[mem_addr];
          b_ack_d   = 1'b1;
        end
        if (READ_CLEARS) valid_d[mem_addr] = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    count_d = '0;
    for (int i = 0; i < DEPTH; i++) count_d += {{ADDR_W{1'b0}}, valid_d[i]};
  end

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      owner     <= REQ_A;
      op_we     <= 1'b0;
      valid     <= '0;
      a_gnt     <= 1'b0;
      b_gnt     <= 1'b0;
      a_ack     <= 1'b0;
      b_ack     <= 1'b0;
      a_rerr    <= 1'b0;
      b_rerr    <= 1'b0;
      a_rdata   <= '0;
      b_rdata   <= '0;
      mem_en_w  <= 1'b0;
      mem_en_r  <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      count     <= '0;
      full      <= 1'b0;
      empty     <= 1'b1;
    end else begin
      owner     <= owner_d;
      op_we     <= op_we_d;
      valid     <= valid_d;
      a_gnt     <= a_gnt_d;
      b_gnt     <= b_gnt_d;
      a_ack     <= a_ack_d;
      b_ack     <= b_ack_d;
      a_rerr    <= a_rerr_d;
      b_rerr    <= b_rerr_d;
      a_rdata   <= a_rdata_d;
      b_rdata   <= b_rdata_d;
      mem_en_w  <= mem_en_w_d;
      mem_en_r  <= mem_en_r_d;
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
      count     <= count_d;
      full      <= (count_d == (ADDR_W+1)'(DEPTH));
      empty     <= (count_d == '0);
    end
endmodule

// File: tb/tb_mem_buffer_arbiter.sv
// Directed bench for mem_buffer_arbiter with a behavioural single-port buffer.
module tb_mem_buffer_arbiter;
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       a_req = 0, a_we = 0, b_req = 0, b_we = 0;
  logic [2:0] a_addr = 0, b_addr = 0;
  logic [7:0] a_wdata = 0, b_wdata = 0;
  logic       a_gnt, a_ack, a_rerr, b_gnt, b_ack, b_rerr;
  logic [7:0] a_rdata, b_rdata, mem_wdata;
  logic [7:0] mem_rdata = 8'h00;
  logic       mem_en_w, mem_en_r, full, empty;
  logic [2:0] mem_addr;
  logic [3:0] count;
  logic [7:0] mem [8];
  int         errors = 0, checks = 0;

  always #5 clk = ~clk;

  mem_buffer_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .a_gnt(a_gnt), .a_ack(a_ack), .a_rdata(a_rdata), .a_rerr(a_rerr),
    .b_gnt(b_gnt), .b_ack(b_ack), .b_rdata(b_rdata), .b_rerr(b_rerr),
    .mem_en_w(mem_en_w), .mem_en_r(mem_en_r), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .full(full), .empty(empty), .count(count)
  );

  // Single-port buffer model, registered read.
  always @(posedge clk) begin
    if (mem_en_w) mem[mem_addr] <= mem_wdata;
    if (mem_en_r) mem_rdata <= mem[mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic a_write(input logic [2:0] ad, input logic [7:0] d);
    a_req = 1; a_we = 1; a_addr = ad; a_wdata = d;
    tick(); chk("wr_gnt", a_gnt, 1);
    a_req = 0;
    tick(); chk("wr_ack", a_ack, 1);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) mem[i] = 8'h00;
    repeat (2) tick();
    chk("rst_empty", empty, 1);
    chk("rst_count", count, 0);
    chk("rst_outs", {a_gnt, b_gnt, a_ack, b_ack, mem_en_w, mem_en_r, full}, 0);
    reset_n = 1; tick();

    // 1: A writes 0x5A to addr 3
    a_req = 1; a_we = 1; a_addr = 3; a_wdata = 8'h5A;
    tick();
    chk("t1_gnt", {a_gnt, b_gnt}, 2'b10);
    chk("t1_en", {mem_en_w, mem_en_r}, 2'b10);
    chk("t1_addr", {mem_addr, mem_wdata}, {3'd3, 8'h5A});
    chk("t1_noack", a_ack, 0);
    a_req = 0;
    tick();
    chk("t1_ack", a_ack, 1);
    chk("t1_en_off", {mem_en_w, mem_en_r, a_gnt}, 0);
    chk("t1_count", count, 1);
    chk("t1_empty", empty, 0);
    tick();
    chk("t1_ack_pulse", a_ack, 0);

    // 2: A reads addr 3, clearing it
    a_req = 1; a_we = 0; a_addr = 3;
    tick();
    chk("t2_gnt", a_gnt, 1);
    chk("t2_en", {mem_en_w, mem_en_r}, 2'b01);
    a_req = 0;
    tick();
    chk("t2_wait", {a_ack, mem_en_r}, 0);
    tick();
    chk("t2_ack", a_ack, 1);
    chk("t2_rdata", a_rdata, 8'h5A);
    chk("t2_rerr", a_rerr, 0);
    chk("t2_count", count, 0);
    chk("t2_empty", empty, 1);

    // 3: both hold write requests from reset; grants alternate A,B,A,B
    reset_n = 0; tick(); reset_n = 1;
    a_req = 1; a_we = 1; a_addr = 0; a_wdata = 8'h11;
    b_req = 1; b_we = 1; b_addr = 1; b_wdata = 8'h22;
    tick(); chk("t3_g0", {a_gnt, b_gnt}, 2'b10);
    tick(); chk("t3_ack0", {a_ack, b_ack}, 2'b10);
    tick(); chk("t3_g1", {a_gnt, b_gnt}, 2'b01);
    chk("t3_wd1", mem_wdata, 8'h22);
    tick(); chk("t3_ack1", {a_ack, b_ack}, 2'b01);
    tick(); chk("t3_g2", {a_gnt, b_gnt}, 2'b10);
    tick();
    tick(); chk("t3_g3", {a_gnt, b_gnt}, 2'b01);
    a_req = 0; b_req = 0;
    tick();
    chk("t3_count", count, 2);

    // 4: fill all entries, then rewrite addr 2
    for (int i = 0; i < 8; i++) a_write(3'(i), 8'(8'hA0 + i));
    chk("t4_full", full, 1);
    chk("t4_count", count, 8);
    a_write(3'd2, 8'hEE);
    chk("t4_rewrite_count", count, 8);
    chk("t4_rewrite_full", full, 1);

    // 5: clear addr 6 via A, then B reads it while invalid
    a_req = 1; a_we = 0; a_addr = 6;
    tick(); a_req = 0; tick(); tick();
    chk("t5_a_rdata", a_rdata, 8'hA6);
    chk("t5_a_count", count, 7);
    chk("t5_notfull", full, 0);
    b_req = 1; b_we = 0; b_addr = 6;
    tick(); chk("t5_bgnt", b_gnt, 1);
    b_req = 0; tick(); tick();
    chk("t5_back", b_ack, 1);
    chk("t5_rerr", b_rerr, 1);
    chk("t5_count", count, 7);

    // 6: reset during RWAIT drops the read
    a_req = 1; a_we = 0; a_addr = 2;
    tick(); a_req = 0; tick();
    reset_n = 0; #1;
    chk("t6_outs", {a_gnt, b_gnt, a_ack, b_ack, a_rerr, b_rerr, mem_en_w, mem_en_r, full}, 0);
    chk("t6_data", {a_rdata, b_rdata, mem_addr, mem_wdata}, 0);
    chk("t6_count", count, 0);
    chk("t6_empty", empty, 1);
    tick();
    chk("t6_noack", a_ack, 0);
    reset_n = 1;
    a_write(3'd5, 8'h3C);
    chk("t6_after_count", count, 1);
    a_req = 1; a_we = 0; a_addr = 5;
    tick(); a_req = 0; tick(); tick();
    chk("t6_after_rd", {a_ack, a_rerr, a_rdata}, {1'b1, 1'b0, 8'h3C});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
